// File: rtl/fetch_stage.sv
// Instruction-fetch stage: architectural PC register, single-outstanding
// req/ack fetch from instruction memory, and a valid/ready IF/ID register
// that is flushed on redirect.
module fetch_stage #(
    parameter int unsigned         DATA_W   = 32,
    parameter logic [DATA_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] next_pc,
    input  logic              redirect,
    output logic [DATA_W-1:0] pc_plus_4,
    output logic [DATA_W-1:0] fetch_pc,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [DATA_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_pc_plus_4,
    input  logic              id_ready
);

    // StDrop: a request is still outstanding but belongs to a flushed path.
    typedef enum logic [1:0] {StIdle, StReq, StFull, StDrop} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] req_addr_q, req_addr_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [DATA_W-1:0] if_pc_q, if_pc_d;
    logic [DATA_W-1:0] if_pc4_q, if_pc4_d;

    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

    // State and datapath registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= word_align(RESET_PC);
            req_addr_q <= word_align(RESET_PC);
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    // Next-state and datapath updates; redirect always wins over id_ready.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        case (state_q)
            StIdle: begin
                state_d    = StReq;
                req_addr_d = pc_q;
            end
            StReq: begin
                if (imem_ack && !redirect) begin
                    if_valid_d = 1'b1;
                    if_instr_d = imem_rdata;
                    if_pc_d    = req_addr_q;
                    if_pc4_d   = req_addr_q + DATA_W'(4);
                    pc_d       = word_align(next_pc);
                    state_d    = StFull;
                end else if (imem_ack && redirect) begin
                    // Returned word is on the squashed path; reissue at target.
                    pc_d       = word_align(next_pc);
                    req_addr_d = word_align(next_pc);
                end else if (redirect) begin
                    // Address must stay stable until the in-flight ack arrives.
                    pc_d    = word_align(next_pc);
                    state_d = StDrop;
                end
            end
            StFull: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    pc_d       = word_align(next_pc);
                    req_addr_d = word_align(next_pc);
                    state_d    = StReq;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    req_addr_d = pc_q;
                    state_d    = StReq;
                end
            end
            StDrop: begin
                if (redirect) begin
                    pc_d = word_align(next_pc);
                end
                if (imem_ack) begin
                    req_addr_d = redirect ? word_align(next_pc) : pc_q;
                    state_d    = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        imem_req     = (state_q == StReq) || (state_q == StDrop);
        imem_addr    = req_addr_q;
        pc_plus_4    = pc_q + DATA_W'(4);
        fetch_pc     = pc_q;
        if_valid     = if_valid_q;
        if_instr     = if_instr_q;
        if_pc        = if_pc_q;
        if_pc_plus_4 = if_pc4_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch path.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] pc_plus_4;
    logic [31:0] fetch_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic        id_ready;

    int tests = 0;
    int fails = 0;

    fetch_stage #(
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .next_pc      (next_pc),
        .redirect     (redirect),
        .pc_plus_4    (pc_plus_4),
        .fetch_pc     (fetch_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus_4 (if_pc_plus_4),
        .id_ready     (id_ready)
    );

    always #5 clk = ~clk;

    // Reference model: one bus transaction in flight at most, one IF/ID slot.
    logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_ipc4;
    bit          m_req;      // a request is on the bus
    bit          m_stale;    // the request on the bus belongs to a squashed path
    bit          m_valid;    // IF/ID slot occupied
    bit          m_started;  // first request has been launched since reset

    function automatic logic [31:0] al(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        m_req = 0; m_stale = 0; m_valid = 0; m_started = 0;
    endtask

    task automatic model_edge(input bit ack, input bit redir, input logic [31:0] npc,
                              input bit rdy, input logic [31:0] rd);
        logic [31:0] tgt;
        if (!m_started) begin
            m_started = 1;
            m_req     = 1;
            m_addr    = m_pc;
        end else if (m_req && !m_stale) begin
            if (ack && !redir) begin
                m_valid = 1; m_instr = rd; m_ipc = m_addr; m_ipc4 = m_addr + 32'd4;
                m_pc    = al(npc);
                m_req   = 0;
            end else if (ack && redir) begin
                m_pc = al(npc); m_addr = al(npc);
            end else if (redir) begin
                m_pc = al(npc); m_stale = 1;
            end
        end else if (m_req && m_stale) begin
            tgt  = redir ? al(npc) : m_pc;
            m_pc = tgt;
            if (ack) begin
                m_addr  = tgt;
                m_stale = 0;
            end
        end else if (m_valid) begin
            if (redir) begin
                m_valid = 0; m_pc = al(npc); m_addr = al(npc); m_req = 1;
            end else if (rdy) begin
                m_valid = 0; m_addr = m_pc; m_req = 1;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("imem_req", imem_req, m_req);
        check_val("imem_addr", imem_addr, m_addr);
        check_val("fetch_pc", fetch_pc, m_pc);
        check_val("pc_plus_4", pc_plus_4, m_pc + 32'd4);
        check_val("if_valid", if_valid, m_valid);
        check_val("if_instr", if_instr, m_instr);
        check_val("if_pc", if_pc, m_ipc);
        check_val("if_pc_plus_4", if_pc_plus_4, m_ipc4);
    endtask

    // Drive inputs at the falling edge, advance one rising edge, compare at next fall.
    task automatic step(input bit ack, input bit redir, input logic [31:0] npc,
                        input bit rdy, input logic [31:0] rd);
        imem_ack   = ack;
        redirect   = redir;
        next_pc    = npc;
        id_ready   = rdy;
        imem_rdata = rd;
        @(posedge clk);
        model_edge(ack, redir, npc, rdy, rd);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_step();
        bit          a, r, y;
        logic [31:0] t;
        a = m_req && ($urandom_range(0, 99) < 55);
        r = $urandom_range(0, 99) < 12;
        y = $urandom_range(0, 99) < 60;
        case ($urandom_range(0, 3))
            0:       t = 32'hFFFF_FFFC;
            1:       t = $urandom & 32'h0000_0FFF;
            default: t = $urandom;
        endcase
        step(a, r, r ? t : m_pc + 32'd4, y, $urandom);
    endtask

    logic [31:0] addrs[$];
    logic [31:0] pcs[$];

    initial begin
        rst        = 1'b1;
        next_pc    = 32'h0;
        redirect   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        id_ready   = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Zero-wait memory, decode always ready: sequential fetch.
        for (int i = 0; i < 9; i++) begin
            if (imem_req) addrs.push_back(imem_addr);
            step(m_req, 1'b0, m_pc + 32'd4, 1'b1, $urandom);
            if (if_valid) pcs.push_back(if_pc);
        end
        for (int i = 0; i < 4; i++) begin
            check_val("seq_imem_addr", (i < addrs.size()) ? addrs[i] : 32'hDEAD_BEEF, i * 4);
            check_val("seq_if_pc", (i < pcs.size()) ? pcs[i] : 32'hDEAD_BEEF, i * 4);
        end

        // Capture at 0x10, then decode stalls for 5 cycles.
        step(1'b1, 1'b0, m_pc + 32'd4, 1'b0, 32'h2002_0005);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, m_pc + 32'd4, 1'b0, $urandom);
            check_val("stall_valid", if_valid, 1'b1);
            check_val("stall_instr", if_instr, 32'h2002_0005);
            check_val("stall_pc", if_pc, 32'h10);
            check_val("stall_req", imem_req, 1'b0);
        end
        step(1'b0, 1'b0, m_pc + 32'd4, 1'b1, $urandom);
        check_val("resume_addr", imem_addr, 32'h14);

        // Redirect while a request is outstanding; ack arrives later.
        step(1'b0, 1'b1, 32'h40, 1'b1, $urandom);
        check_val("drop_req", imem_req, 1'b1);
        check_val("drop_addr_held", imem_addr, 32'h14);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, m_pc + 32'd4, 1'b1, $urandom);
            check_val("drop_addr_held", imem_addr, 32'h14);
        end
        step(1'b1, 1'b0, m_pc + 32'd4, 1'b1, $urandom);
        check_val("drop_discard_valid", if_valid, 1'b0);
        check_val("drop_next_addr", imem_addr, 32'h40);

        // Redirect coinciding with ack at 0x10.
        step(1'b1, 1'b1, 32'h10, 1'b1, $urandom);
        check_val("redir_ack_setup", imem_addr, 32'h10);
        step(1'b1, 1'b1, 32'h80, 1'b1, 32'hBAD0_0010);
        check_val("redir_ack_valid", if_valid, 1'b0);
        check_val("redir_ack_addr", imem_addr, 32'h80);

        // Redirect and id_ready together in the full state.
        step(1'b1, 1'b0, m_pc + 32'd4, 1'b0, $urandom);
        check_val("full_valid", if_valid, 1'b1);
        check_val("full_pc", if_pc, 32'h80);
        step(1'b0, 1'b1, 32'h100, 1'b1, $urandom);
        check_val("squash_valid", if_valid, 1'b0);
        check_val("squash_addr", imem_addr, 32'h100);

        // PC wrap and target alignment.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, $urandom);
        check_val("wrap_fetch_pc", fetch_pc, 32'hFFFF_FFFC);
        check_val("wrap_pc_plus_4", pc_plus_4, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0013, 1'b1, $urandom);
        check_val("align_addr", imem_addr, 32'h10);

        // Random traffic.
        for (int i = 0; i < 3000; i++) rand_step();

        // Asynchronous reset while a request is outstanding.
        for (int i = 0; i < 20 && !m_req; i++) step(1'b0, 1'b0, m_pc + 32'd4, 1'b1, $urandom);
        check_val("pre_reset_req", imem_req, 1'b1);
        #2;
        rst      = 1'b1;
        imem_ack = 1'b1;
        #1;
        check_val("async_reset_req", imem_req, 1'b0);
        check_val("async_reset_valid", if_valid, 1'b0);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        step(1'b1, 1'b0, 32'h4, 1'b1, $urandom);
        check_val("post_reset_addr", imem_addr, 32'h0);
        check_val("post_reset_req", imem_req, 1'b1);
        for (int i = 0; i < 300; i++) rand_step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
